// File: rtl/aes_rkey_arbiter.sv
// Round-key store for an AES datapath: host-loaded key slots, shared by an encrypt and a
// decrypt core through a single round-robin read port with one-cycle latency.
module aes_rkey_arbiter #(
  parameter int unsigned NKEYS = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   key_len,
  input  logic         wr_en,
  input  logic [3:0]   wr_addr,
  input  logic [127:0] wr_data,
  output logic         keys_ready,
  input  logic         req0,
  input  logic [3:0]   addr0,
  output logic [127:0] key0,
  output logic         valid0,
  input  logic         req1,
  input  logic [3:0]   addr1,
  output logic [127:0] key1,
  output logic         valid1,
  output logic         addr_err
);

  logic [127:0]     slots [NKEYS];
  logic [NKEYS-1:0] mask_q, mask_d;
  logic [1:0]       key_len_q;
  logic             keys_ready_q, keys_ready_d;
  logic             valid0_q, valid1_q, addr_err_q;
  logic [127:0]     key0_q, key1_q;
  logic             prio_q;  // requester that wins when both are eligible

  logic [3:0]   nr;
  logic         nr_ok;
  logic         len_changed;
  logic         wr_hit;
  logic [15:0]  mask_pad;
  logic [15:0]  need;
  logic         all_loaded;
  logic         elig0, elig1;
  logic         gnt0, gnt1;
  logic [3:0]   rd_addr;
  logic         rd_oor;
  logic [127:0] rd_data;

  always_comb begin
    nr    = 4'd0;
    nr_ok = 1'b1;
    case (key_len)
      2'b01:   nr = 4'd10;
      2'b10:   nr = 4'd12;
      2'b11:   nr = 4'd14;
      default: nr_ok = 1'b0;
    endcase
  end

  assign len_changed = (key_len != key_len_q);
  assign wr_hit      = wr_en && ({1'b0, wr_addr} < 5'(NKEYS));

  // Slots beyond NKEYS read as unloaded, so a schedule that does not fit never becomes ready.
  always_comb begin
    mask_pad = '0;
    mask_pad[NKEYS-1:0] = mask_q;
    for (int i = 0; i < 16; i++) begin
      need[i] = (i <= int'(nr));
    end
    all_loaded = nr_ok && ((mask_pad & need) == need);
  end

  always_comb begin
    mask_d = len_changed ? '0 : mask_q;
    if (wr_hit) begin
      mask_d[wr_addr] = 1'b1;
    end
    keys_ready_d = all_loaded && !wr_en && !len_changed;
  end

  assign elig0 = req0 && keys_ready_q && !wr_en && !valid0_q;
  assign elig1 = req1 && keys_ready_q && !wr_en && !valid1_q;

  always_comb begin
    if (elig0 && elig1) begin
      gnt0 = !prio_q;
      gnt1 = prio_q;
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end
  end

  assign rd_addr = gnt1 ? addr1 : addr0;
  assign rd_oor  = (rd_addr > nr);

  always_comb begin
    rd_data = '0;
    if (!rd_oor && ({1'b0, rd_addr} < 5'(NKEYS))) begin
      rd_data = slots[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_hit) begin
      slots[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_len_q    <= key_len;
      mask_q       <= '0;
      keys_ready_q <= 1'b0;
      valid0_q     <= 1'b0;
      valid1_q     <= 1'b0;
      addr_err_q   <= 1'b0;
      key0_q       <= '0;
      key1_q       <= '0;
      prio_q       <= 1'b0;
    end else begin
      key_len_q    <= key_len;
      mask_q       <= mask_d;
      keys_ready_q <= keys_ready_d;
      valid0_q     <= gnt0;
      valid1_q     <= gnt1;
      addr_err_q   <= (gnt0 || gnt1) && rd_oor;
      if (gnt0) begin
        key0_q <= rd_data;
        prio_q <= 1'b1;
      end
      if (gnt1) begin
        key1_q <= rd_data;
        prio_q <= 1'b0;
      end
    end
  end

  assign keys_ready = keys_ready_q;
  assign valid0     = valid0_q;
  assign valid1     = valid1_q;
  assign addr_err   = addr_err_q;
  assign key0       = key0_q;
  assign key1       = key1_q;

endmodule

// File: tb/tb_aes_rkey_arbiter.sv
// Bench for aes_rkey_arbiter: a cycle-level reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_aes_rkey_arbiter;

  localparam int NK = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   key_len = 2'b01;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [127:0] wr_data = '0;
  logic         keys_ready;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [3:0]   addr0 = '0, addr1 = '0;
  logic [127:0] key0, key1;
  logic         valid0, valid1, addr_err;

  always #5 clk = ~clk;

  aes_rkey_arbiter #(.NKEYS(NK)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_len    (key_len),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .keys_ready (keys_ready),
    .req0       (req0),
    .addr0      (addr0),
    .key0       (key0),
    .valid0     (valid0),
    .req1       (req1),
    .addr1      (addr1),
    .key1       (key1),
    .valid1     (valid1),
    .addr_err   (addr_err)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [127:0] kval(input int i);
    return {4{16'(i), 16'hC0DE}};
  endfunction

  function automatic int nr_of(input logic [1:0] kl);
    case (kl)
      2'b01:   return 10;
      2'b10:   return 12;
      2'b11:   return 14;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must be after each edge
  logic [127:0] m_mem [NK];
  bit           m_loaded [NK];
  logic [1:0]   m_klen;
  bit           m_ready, m_v0, m_v1, m_err, m_live;
  logic [127:0] m_k0, m_k1;
  int           m_turn;

  initial begin
    int nr, g, a;
    bit e0, e1, full;
    logic [127:0] d;
    m_live = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < NK; i++) m_loaded[i] = 1'b0;
        m_ready = 0; m_v0 = 0; m_v1 = 0; m_err = 0;
        m_k0 = '0; m_k1 = '0; m_turn = 0;
        m_klen = key_len;
        m_live = 1'b1;
      end else begin
        nr = nr_of(key_len);
        e0 = req0 && m_ready && !wr_en && !m_v0;
        e1 = req1 && m_ready && !wr_en && !m_v1;
        g = -1;
        if (e0 && e1) g = m_turn;
        else if (e0) g = 0;
        else if (e1) g = 1;
        m_v0 = (g == 0);
        m_v1 = (g == 1);
        m_err = 1'b0;
        if (g >= 0) begin
          a = (g == 0) ? int'(addr0) : int'(addr1);
          d = '0;
          if (a <= nr && a < NK) d = m_mem[a];
          m_err = (a > nr);
          if (g == 0) m_k0 = d;
          else m_k1 = d;
          m_turn = 1 - g;
        end
        full = (nr >= 0);
        for (int i = 0; i <= nr; i++) begin
          if (i >= NK) full = 1'b0;
          else if (!m_loaded[i]) full = 1'b0;
        end
        m_ready = full && !wr_en && (key_len == m_klen);
        if (key_len != m_klen) for (int i = 0; i < NK; i++) m_loaded[i] = 1'b0;
        if (wr_en && int'(wr_addr) < NK) begin
          m_mem[wr_addr] = wr_data;
          m_loaded[wr_addr] = 1'b1;
        end
        m_klen = key_len;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("model keys_ready", keys_ready, m_ready);
        chk("model valid0", valid0, m_v0);
        chk("model valid1", valid1, m_v1);
        chk("model addr_err", addr_err, m_err);
        chk("model key0", key0, m_k0);
        chk("model key1", key1, m_k1);
        chk("model valid exclusive", valid0 && valid1, 1'b0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = kval(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_valid(input int which, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (((which == 0) ? valid0 : valid1) !== 1'b1 && waited < 8);
    if (((which == 0) ? valid0 : valid1) !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_valid%0d: got no pulse, expected one within %0d cycles", which, waited);
    end
  endtask

  initial begin
    int w;
    tick(); tick();
    chk("reset keys_ready", keys_ready, 1'b0);
    chk("reset valid0", valid0, 1'b0);
    chk("reset valid1", valid1, 1'b0);
    chk("reset addr_err", addr_err, 1'b0);
    chk("reset key0", key0, '0);
    chk("reset key1", key1, '0);
    reset = 1'b0;

    // AES-128 load
    load(11);
    chk("ready low right after last write", keys_ready, 1'b0);
    tick();
    chk("ready after load", keys_ready, 1'b1);

    // Single requester walking the schedule backwards
    req1 = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      addr1 = 4'(i);
      wait_valid(1, w);
      chk("single key1", key1, kval(i));
      chk("single spacing", w, (i == 10) ? 1 : 2);
      if (i == 10) chk("key1 K10 literal", key1, 128'h000AC0DE_000AC0DE_000AC0DE_000AC0DE);
    end
    chk("key1 K0 literal", key1, 128'h0000C0DE_0000C0DE_0000C0DE_0000C0DE);
    req1 = 1'b0;
    tick();

    // Write priority over an active requester
    req1 = 1'b1; addr1 = 4'd7;
    wait_valid(1, w);
    chk("pre-write key1", key1, 128'h0007C0DE_0007C0DE_0007C0DE_0007C0DE);
    tick();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = {4{32'h5555_AAAA}};
    tick();
    chk("write blocks grant", valid1, 1'b0);
    chk("write drops ready", keys_ready, 1'b0);
    wr_en = 1'b0; addr1 = 4'd5;
    tick();
    chk("ready back, no grant yet", valid1, 1'b0);
    chk("ready restored", keys_ready, 1'b1);
    tick();
    chk("grant resumes", valid1, 1'b1);
    chk("new slot5 data", key1, {4{32'h5555_AAAA}});
    req1 = 1'b0;
    tick();

    // Range check at and beyond Nr for AES-128
    req0 = 1'b1; addr0 = 4'd12;
    wait_valid(0, w);
    chk("oor key0 zero", key0, '0);
    chk("oor addr_err", addr_err, 1'b1);
    addr0 = 4'd10;
    wait_valid(0, w);
    chk("Nr key0", key0, kval(10));
    chk("Nr no addr_err", addr_err, 1'b0);
    req0 = 1'b0;
    tick();

    // Contention right after reset: requester 0 first, then alternate
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ready cleared by reset", keys_ready, 1'b0);
    load(11);
    tick();
    chk("ready after reload", keys_ready, 1'b1);
    req0 = 1'b1; req1 = 1'b1; addr0 = 4'd3; addr1 = 4'd6;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("contend valid0", valid0, (k % 2) == 0);
      chk("contend valid1", valid1, (k % 2) == 1);
    end
    chk("contend key0", key0, 128'h0003C0DE_0003C0DE_0003C0DE_0003C0DE);
    chk("contend key1", key1, 128'h0006C0DE_0006C0DE_0006C0DE_0006C0DE);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // AES-192: key_len change clears the mask; slot 12 completes the schedule
    key_len = 2'b10;
    tick();
    chk("klen change clears ready", keys_ready, 1'b0);
    load(12);
    tick(); tick();
    chk("192 partial not ready", keys_ready, 1'b0);
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = kval(12);
    tick();
    wr_en = 1'b0;
    tick();
    chk("192 ready", keys_ready, 1'b1);
    req0 = 1'b1; addr0 = 4'd12;
    wait_valid(0, w);
    chk("192 Nr key0", key0, 128'h000CC0DE_000CC0DE_000CC0DE_000CC0DE);
    chk("192 Nr no err", addr_err, 1'b0);
    addr0 = 4'd13;
    wait_valid(0, w);
    chk("192 oor key0", key0, '0);
    chk("192 oor err", addr_err, 1'b1);
    req0 = 1'b0;
    tick();

    // Reset on the edge that would register a grant
    req1 = 1'b1; addr1 = 4'd4;
    wait_valid(1, w);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset kills pulse", valid1, 1'b0);
    chk("reset key1", key1, '0);
    chk("reset ready", keys_ready, 1'b0);
    repeat (4) tick();
    chk("blocked after reset", valid1, 1'b0);
    load(13);
    tick();
    chk("ready after 192 reload", keys_ready, 1'b1);
    wait_valid(1, w);
    chk("post-reset key1", key1, kval(4));
    req1 = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_rkey_arbiter.md
AES_RKEY_ARBITER -- requirements
Module: aes_rkey_arbiter

Interface
REQ-001 SHALL have parameter NKEYS, default 15, meaning number of 128-bit round-key slots (indices 0..NKEYS-1).
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port key_len, input, 2 bits: 01 = AES-128, 10 = AES-192, 11 = AES-256, 00 = invalid.
REQ-005 SHALL have port wr_en, input, 1 bit: host round-key write strobe.
REQ-006 SHALL have port wr_addr, input, 4 bits: slot index to write.
REQ-007 SHALL have port wr_data, input, 128 bits: round-key data.
REQ-008 SHALL have port keys_ready, output, 1 bit: full key schedule for current key_len is loaded.
REQ-009 SHALL have ports req0/req1, input, 1 bit each: requester 0 (encrypt core) / requester 1 (decrypt core) wants a key.
REQ-010 SHALL have ports addr0/addr1, input, 4 bits each: requested slot index.
REQ-011 SHALL have ports key0/key1, output, 128 bits each: returned round key.
REQ-012 SHALL have ports valid0/valid1, output, 1 bit each: one-cycle pulse, keyN holds data for addrN sampled in the grant cycle.
REQ-013 SHALL have port addr_err, output, 1 bit: one-cycle pulse, a granted address exceeded Nr.

Function
REQ-014 SHALL define Nr = 10/12/14 for key_len 01/10/11; key_len 00 has no valid Nr.
REQ-015 SHALL store keys in NKEYS x 128 registers; wr_en writes wr_data to slot wr_addr at the clock edge; wr_addr >= NKEYS is ignored.
REQ-016 SHALL keep a NKEYS-bit loaded mask; each accepted write sets its bit.
REQ-017 SHALL register keys_ready = (key_len != 00) AND mask bits 0..Nr all set AND no wr_en this cycle.
REQ-018 SHALL clear the mask and keys_ready on the cycle after key_len changes value; key_len is registered internally for change detection.
REQ-019 SHALL treat requester N as eligible in a cycle when reqN=1, keys_ready=1, wr_en=0 and validN=0 (a requester is never granted in the cycle its valid is high, so it can update addrN before its next grant).
REQ-020 SHALL grant at most one requester per cycle (single read port).
REQ-021 SHALL arbitrate round-robin: with both eligible, grant the requester not granted most recently; with one eligible, grant it; the priority pointer updates only on a grant.
REQ-022 SHALL, on grant of N, drive next cycle keyN = slot[addrN] (value before any same-edge write), validN = 1; otherwise validN = 0 and keyN holds its last value.
REQ-023 SHALL, when the granted addrN > Nr, return keyN = 0, validN = 1 and addr_err = 1 in the same cycle.
REQ-024 SHALL give wr_en absolute priority: no grant in any cycle with wr_en=1.
REQ-025 SHALL deassert valid for a requester whose reqN drops; a pulse already scheduled still completes.
REQ-026 SHALL guarantee read latency exactly 1 cycle from grant; each requester receives at most one key every 2 cycles.

Reset
REQ-027 SHALL on reset clear mask, keys_ready, valid0, valid1, addr_err, key0, key1 (all 0) and priority pointer (requester 0 first); key storage contents are not cleared.
REQ-028 SHALL make reset dominate wr_en and req in the same cycle; a pulse scheduled before reset is suppressed.

Verification
REQ-029 Load: key_len=01, write slots 0..10 with 128'hK_i -> keys_ready rises one cycle after last write; slots 11..14 unwritten do not matter.
REQ-030 Single requester: req1=1, addr1=10 then 9..0 after each valid1 -> valid1 pulses every 2 cycles, key1 = K_10..K_0 in order, valid0 stays 0.
REQ-031 Contention: req0=req1=1 from same cycle after reset -> grants alternate 0,1,0,1; valid0 and valid1 never high together.
REQ-032 Write priority: wr_en=1 during active req1 -> no valid that following cycle, keys_ready drops, resumes after re-load of mask completes.
REQ-033 Range: key_len=01, addr0=12 -> key0=0, valid0=1, addr_err=1 same cycle.
REQ-034 Reset mid-run: assert reset while valid1 pending -> next cycle valid1=0, key1=0, keys_ready=0; reads blocked until all slots 0..Nr rewritten.
